exu_regfile: RTL and testbench
==============================

// Module: exu_regfile
// PURPOSE
//   Integer register file. It is the receiving end of the EXU writeback interface
//   (rf_wbck_*) and supplies operands to decode/ALU through two read ports.
//   x0 is hardwired to zero. Optional write-to-read bypass. Also provides a debug
//   read port and a retired-write counter for difftest and coverage.
// PARAMETERS
//   XLEN         32  data width of each register
//   RFIDX_WIDTH  5   register index width
//   RFREG_NUM    32  number of architectural registers (<= 2**RFIDX_WIDTH)
//   BYPASS       1   1: a same-cycle write is forwarded to the read ports; 0: no forwarding
//   CNT_WIDTH    32  width of the retired-write counter
// PORTS
//   clk              in   1            core clock; all state updates on the rising edge
//   rst_n            in   1            asynchronous reset, active-low
//   rf_wbck_i_ena    in   1            write enable from the writeback stage
//   rf_wbck_i_wdat   in   XLEN         write data
//   rf_wbck_i_rdidx  in   RFIDX_WIDTH  destination register index
//   rf_wbck_i_ready  out  1            write acceptance; tied to 1
//   read_src1_idx    in   RFIDX_WIDTH  read port 1 index
//   read_src2_idx    in   RFIDX_WIDTH  read port 2 index
//   read_src1_dat    out  XLEN         read port 1 data (combinational)
//   read_src2_dat    out  XLEN         read port 2 data (combinational)
//   dbg_rdidx        in   RFIDX_WIDTH  debug read index
//   dbg_rddat        out  XLEN         debug read data; never bypassed, shows committed state
//   rf_wr_cnt        out  CNT_WIDTH    number of committed writes to x1..x(RFREG_NUM-1)
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous):
//     - all registers <= 0; rf_wr_cnt <= 0.
//     - rf_wbck_i_ready is 1 at all times, including during reset.
//     - Read outputs reflect the zeroed array immediately.
//     - A write in progress when reset asserts is lost; the register stays 0.
//   Write:
//     - Handshake is rf_wbck_i_ena & rf_wbck_i_ready. Ready is always 1, so ena
//       alone commits.
//     - Commit is on the next rising edge. Latency is 1 cycle to the array.
//     - One write per cycle.
//     - Writes with rdidx==0, or rdidx>=RFREG_NUM, are discarded: array unchanged,
//       counter unchanged.
//     - Each committed write increments rf_wr_cnt by 1, wrapping modulo
//       2**CNT_WIDTH (all-ones+1 -> 0).
//   Read:
//     - Purely combinational from the index. Index 0 always returns 0.
//     - An index >= RFREG_NUM returns 0.
//   Bypass, BYPASS=1:
//     - If rf_wbck_i_ena=1, rdidx!=0, and rdidx equals a read index in the same
//       cycle, that port returns rf_wbck_i_wdat instead of the stored value.
//     - Both ports may bypass at the same time.
//   Bypass, BYPASS=0:
//     - Read ports return the stored (old) value until the edge after the write.
//   Read and write of the same register in the same cycle: read follows the BYPASS
//   rule; the array holds the new value after the edge.
//   No internal FSM. State is the register array (x1..x(RFREG_NUM-1)) plus rf_wr_cnt.
// TESTING
//   1. Reset
//      - Stimulus: rst_n=0 for 2 cycles, then release.
//      - Required: all read ports and dbg_rddat read 0 for every index;
//        rf_wr_cnt=0; rf_wbck_i_ready=1.
//   2. Basic write/read
//      - Stimulus: write x5=0xDEADBEEF.
//      - Required: next cycle read_src1_idx=5 gives 0xDEADBEEF; rf_wr_cnt=1.
//   3. x0 protection
//      - Stimulus: write x0=0xFFFFFFFF.
//      - Required: read x0=0 on both ports; rf_wr_cnt unchanged.
//   4. Bypass
//      - Stimulus: BYPASS=1, with x7=0x11. Write x7=0x22 while src1=src2=7 in the
//        same cycle.
//      - Required: both read ports give 0x22 in that cycle; dbg_rddat(7)=0x11 in
//        that cycle and 0x22 after the edge.
//      - Repeat with BYPASS=0: read ports give 0x11 in that cycle.
//   5. Async reset mid-write
//      - Stimulus: rf_wbck_i_ena=1 for x3=0x55; assert rst_n low between clock
//        edges.
//      - Required: x3 reads 0 immediately after reset asserts; rf_wr_cnt=0.
//   6. Counter wrap
//      - Stimulus: CNT_WIDTH=4; perform 17 legal writes.
//      - Required: rf_wr_cnt=1.

Source files
------------

// File: rtl/exu_regfile_if.sv
// Writeback bus into the integer register file.
//   rf_wbck_i_ena    writeback stage -> regfile : write request
//   rf_wbck_i_wdat   writeback stage -> regfile : write data
//   rf_wbck_i_rdidx  writeback stage -> regfile : destination register index
//   rf_wbck_i_ready  regfile -> writeback stage : write acceptance (always 1)
interface exu_regfile_if #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5
);
  logic                   rf_wbck_i_ena;
  logic [XLEN-1:0]        rf_wbck_i_wdat;
  logic [RFIDX_WIDTH-1:0] rf_wbck_i_rdidx;
  logic                   rf_wbck_i_ready;

  modport master (output rf_wbck_i_ena, rf_wbck_i_wdat, rf_wbck_i_rdidx,
                  input  rf_wbck_i_ready);
  modport slave  (input  rf_wbck_i_ena, rf_wbck_i_wdat, rf_wbck_i_rdidx,
                  output rf_wbck_i_ready);
endinterface

// File: rtl/exu_regfile.sv
// Integer register file with two combinational read ports, a debug read port
// (committed state only), optional write->read bypass and a retired-write counter.
//   clk, rst_n          clock, asynchronous active-low reset
//   wbck (slave)        writeback bus: ena / wdat / rdidx in, ready out
//   read_src1/2_idx     read port indices
//   read_src1/2_dat     read port data (combinational, bypassed when BYPASS=1)
//   dbg_rdidx/rddat     debug read, never bypassed
//   rf_wr_cnt           count of committed writes to x1..x(RFREG_NUM-1), wraps

// One architectural register; x0 is not instantiated.
module exu_rf_entry #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [XLEN-1:0] i_wdat,
  output logic [XLEN-1:0] o_q
);
  logic [XLEN-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_we) r_q <= i_wdat;
  end

  assign o_q = r_q;
endmodule

module exu_regfile #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int RFREG_NUM   = 32,
  parameter int BYPASS      = 1,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  exu_regfile_if.slave           wbck,
  input  logic [RFIDX_WIDTH-1:0] read_src1_idx,
  input  logic [RFIDX_WIDTH-1:0] read_src2_idx,
  output logic [XLEN-1:0]        read_src1_dat,
  output logic [XLEN-1:0]        read_src2_dat,
  input  logic [RFIDX_WIDTH-1:0] dbg_rdidx,
  output logic [XLEN-1:0]        dbg_rddat,
  output logic [CNT_WIDTH-1:0]   rf_wr_cnt
);
  logic [RFREG_NUM-1:0][XLEN-1:0] w_regs;
  logic                           w_wr_legal;
  logic [CNT_WIDTH-1:0]           r_wr_cnt;

  // Ready is unconditional, so acceptance never depends on state or reset.
  assign wbck.rf_wbck_i_ready = 1'b1;

  // Writes to x0 or past the implemented registers are dropped entirely.
  assign w_wr_legal = wbck.rf_wbck_i_ena & wbck.rf_wbck_i_ready
                    & (wbck.rf_wbck_i_rdidx != '0)
                    & (int'(wbck.rf_wbck_i_rdidx) < RFREG_NUM);

  assign w_regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < RFREG_NUM; gi++) begin : g_reg
      exu_rf_entry #(.XLEN(XLEN)) u_entry (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_wr_legal && (wbck.rf_wbck_i_rdidx == RFIDX_WIDTH'(gi))),
        .i_wdat (wbck.rf_wbck_i_wdat),
        .o_q    (w_regs[gi])
      );
    end
  endgenerate

  // Out-of-range indices read 0 and are never bypassed, since a write there
  // never lands in the array either.
  function automatic logic [XLEN-1:0] rd_port(input logic [RFIDX_WIDTH-1:0] idx,
                                              input logic byp_en);
    logic [XLEN-1:0] v;
    v = '0;
    if (int'(idx) < RFREG_NUM) begin
      v = w_regs[idx];
      if (byp_en && w_wr_legal && (wbck.rf_wbck_i_rdidx == idx))
        v = wbck.rf_wbck_i_wdat;
    end
    return v;
  endfunction

  always_comb begin
    read_src1_dat = rd_port(read_src1_idx, BYPASS != 0);
    read_src2_dat = rd_port(read_src2_idx, BYPASS != 0);
    dbg_rddat     = rd_port(dbg_rdidx, 1'b0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_wr_cnt <= '0;
    else if (w_wr_legal) r_wr_cnt <= r_wr_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  assign rf_wr_cnt = r_wr_cnt;
endmodule

// File: tb/tb_exu_regfile.sv
module tb_exu_regfile;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [31:0] wdat = '0;
  logic [4:0]  wr = '0, s1 = '0, s2 = '0, dbg = '0;

  // A: 32 regs, bypass, 32-bit counter. B: 24 regs, no bypass, 4-bit counter.
  logic [31:0] a1, a2, ad, ac, b1, b2, bd;
  logic [3:0]  bc;

  always #5 clk = ~clk;

  exu_regfile_if #(.XLEN(32), .RFIDX_WIDTH(5)) ifa ();
  exu_regfile_if #(.XLEN(32), .RFIDX_WIDTH(5)) ifb ();
  assign ifa.rf_wbck_i_ena = ena;  assign ifa.rf_wbck_i_wdat = wdat;  assign ifa.rf_wbck_i_rdidx = wr;
  assign ifb.rf_wbck_i_ena = ena;  assign ifb.rf_wbck_i_wdat = wdat;  assign ifb.rf_wbck_i_rdidx = wr;

  exu_regfile #(.XLEN(32), .RFIDX_WIDTH(5), .RFREG_NUM(32), .BYPASS(1), .CNT_WIDTH(32)) ua (
    .clk(clk), .rst_n(rst_n), .wbck(ifa),
    .read_src1_idx(s1), .read_src2_idx(s2), .read_src1_dat(a1), .read_src2_dat(a2),
    .dbg_rdidx(dbg), .dbg_rddat(ad), .rf_wr_cnt(ac));
  exu_regfile #(.XLEN(32), .RFIDX_WIDTH(5), .RFREG_NUM(24), .BYPASS(0), .CNT_WIDTH(4)) ub (
    .clk(clk), .rst_n(rst_n), .wbck(ifb),
    .read_src1_idx(s1), .read_src2_idx(s2), .read_src1_dat(b1), .read_src2_dat(b2),
    .dbg_rdidx(dbg), .dbg_rddat(bd), .rf_wr_cnt(bc));

  typedef struct {
    logic [31:0] a1, a2, ad, ac, b1, b2, bd;
    logic [3:0]  bc;
  } exp_t;
  exp_t q[$];

  // Reference model: plain arrays and integer counters.
  logic [31:0] arrA [32];
  logic [31:0] arrB [32];
  int unsigned cntA, cntB;
  int n_cmp = 0, n_bad = 0;

  function automatic logic [31:0] mrd(bit isB, int idx, bit byp);
    int nreg = isB ? 24 : 32;
    if (idx == 0 || idx >= nreg) return 32'h0;
    if (byp && ena && int'(wr) == idx) return wdat;
    return isB ? arrB[idx] : arrA[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin arrA[i] = '0; arrB[i] = '0; end
    cntA = 0; cntB = 0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.a1 = mrd(0, s1, 1);  e.a2 = mrd(0, s2, 1);  e.ad = mrd(0, dbg, 0);  e.ac = cntA;
    e.b1 = mrd(1, s1, 0);  e.b2 = mrd(1, s2, 0);  e.bd = mrd(1, dbg, 0);  e.bc = 4'(cntB);
    q.push_back(e);
  endtask

  // The write driven this cycle lands at the coming edge if not in reset.
  task automatic model_commit();
    if (rst_n && ena && wr != 0) begin
      arrA[wr] = wdat; cntA++;
      if (wr < 24) begin arrB[wr] = wdat; cntB = (cntB + 1) % 16; end
    end
  endtask

  task automatic step(bit e, int w, logic [31:0] d, int r1, int r2, int rd);
    @(posedge clk); #1;
    ena = e; wr = 5'(w); wdat = d; s1 = 5'(r1); s2 = 5'(r2); dbg = 5'(rd);
    push_exp();
    model_commit();
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each negedge the outputs are stable and one expectation is due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("A.src1", a1, e.a1);  chk("A.src2", a2, e.a2);
        chk("A.dbg", ad, e.ad);   chk("A.cnt", ac, e.ac);
        chk("A.ready", 32'(ifa.rf_wbck_i_ready), 32'h1);
        chk("B.src1", b1, e.b1);  chk("B.src2", b2, e.b2);
        chk("B.dbg", bd, e.bd);   chk("B.cnt", 32'(bc), 32'(e.bc));
        chk("B.ready", 32'(ifb.rf_wbck_i_ready), 32'h1);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    ena = 0; rst_n = 0; model_reset();
    push_exp();
    step(0, 0, 0, 1, 2, 3);
    @(posedge clk); #1 rst_n = 1;
    ena = 0;
  endtask

  initial begin
    int w, r1, r2;
    model_reset();
    // Reset held for 2 cycles; reads checked while in reset.
    step(0, 0, 0, 5, 6, 7);
    step(1, 9, 32'h1234_5678, 9, 9, 9);  // write during reset is ignored
    @(posedge clk); #1 rst_n = 1; ena = 0;
    for (int i = 0; i < 32; i++) step(0, 0, 0, i, 31 - i, i);

    // Basic write/read and x0 protection.
    step(1, 5, 32'hDEAD_BEEF, 5, 0, 5);
    step(0, 0, 0, 5, 5, 5);
    step(1, 0, 32'hFFFF_FFFF, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Bypass: x7=0x11 then x7=0x22 while both ports and dbg read x7.
    step(1, 7, 32'h11, 0, 0, 0);
    step(1, 7, 32'h22, 7, 7, 7);
    step(0, 0, 0, 7, 7, 7);
    // Write beyond B's 24 registers: legal for A only.
    step(1, 28, 32'hCAFE_0028, 28, 28, 28);
    step(0, 0, 0, 28, 28, 28);

    // Random traffic, biased so reads often hit the write target.
    for (int n = 0; n < 400; n++) begin
      w  = int'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? w : int'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? w : int'($urandom_range(0, 31));
      step($urandom_range(0, 2) != 0, w, $urandom, r1, r2, ($urandom_range(0, 1) != 0) ? w : r1);
    end

    // Counter wrap: 17 legal writes on a fresh file -> B's 4-bit counter reads 1.
    do_reset();
    for (int n = 0; n < 17; n++) step(1, 1 + (n % 20), 32'h100 + n, 1, 2, 3);
    step(0, 0, 0, 1, 2, 3);

    // Async reset between edges with a write pending: x3 must stay 0.
    step(1, 3, 32'h33, 3, 3, 3);
    @(posedge clk); #1;
    ena = 1; wr = 5'd3; wdat = 32'h55; s1 = 5'd4; s2 = 5'd2; dbg = 5'd3;
    #2 rst_n = 0; model_reset();
    push_exp();
    @(posedge clk); #1;
    ena = 0; s1 = 5'd3; s2 = 5'd3;
    push_exp();
    @(posedge clk); #1 rst_n = 1;
    push_exp();
    step(0, 0, 0, 3, 3, 3);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
